// File: rtl/stage3_prefetch_buffer.sv
// Instruction prefetch buffer: fetches sequential words over a single-outstanding
// read bus into a DEPTH-entry FIFO, with flush/redirect and stale-read discard.
module stage3_prefetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] bus_addr,
    output logic        bus_ren,
    output logic [3:0]  bus_byte_en,
    input  logic        bus_busy,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     disc_addr_q, disc_addr_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic complete;
    logic push;
    logic pop;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshakes: a head entry transfers when inst_valid && inst_ready (and no
    // flush); a bus read transfers when bus_ren && !bus_busy.
    assign complete    = bus_ren && !bus_busy;
    assign push        = (state_q == REQ) && complete && !flush;
    assign pop         = inst_valid && inst_ready && !flush;

    assign inst_valid  = (count_q != '0);
    assign inst        = inst_mem_q[head_q];
    assign inst_pc     = pc_mem_q[head_q];
    assign bus_ren     = (state_q != IDLE);
    assign bus_addr    = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;
    assign bus_byte_en = 4'hF;
    assign dbg_state_o = state_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (pop) head_d = head_q + AW'(1);
            if (push) tail_d = tail_q + AW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        case (state_q)
            IDLE: begin
                if (!flush && (count_q < FULL)) state_d = REQ;
            end
            REQ: begin
                // A flushed read still owns the bus until it completes; keep its address.
                if (flush) begin
                    if (complete) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = DISCARD;
                        disc_addr_d = fetch_pc_q;
                    end
                end else if (complete && (count_d >= FULL)) begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (complete) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            disc_addr_q <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem_q[tail_q]   <= fetch_pc_q;
            inst_mem_q[tail_q] <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_stage3_prefetch_buffer.sv
// Directed and randomized bench for stage3_prefetch_buffer against a
// transaction-level model (entry queues plus one outstanding-read record).
module tb_stage3_prefetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h80000000;
    localparam int          DEPTH    = 4;
    localparam int          NONE     = 0;
    localparam int          LIVE     = 1;
    localparam int          STALE    = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] bus_addr;
    logic        bus_ren;
    logic [3:0]  bus_byte_en;
    logic        bus_busy;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] m_next;
    logic [31:0] m_req_addr;
    int          m_req;

    stage3_prefetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .bus_addr    (bus_addr),
        .bus_ren     (bus_ren),
        .bus_byte_en (bus_byte_en),
        .bus_busy    (bus_busy),
        .bus_rdata   (bus_rdata),
        .dbg_state_o (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pc_q.delete();
        m_next     = RESET_PC;
        m_req_addr = RESET_PC;
        m_req      = NONE;
    endtask

    task automatic check_outputs();
        check("bus_ren", {31'd0, bus_ren}, {31'd0, m_req != NONE});
        if (m_req != NONE) check("bus_addr", bus_addr, m_req_addr);
        check("bus_byte_en", {28'd0, bus_byte_en}, 32'h0000000F);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("inst_pc", inst_pc, exp_pc_q[0]);
            check("inst", inst, exp_q[0]);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs held across it.
    task automatic model_edge();
        bit completing;
        int size_before;
        completing  = (m_req != NONE) && !bus_busy;
        size_before = exp_q.size();
        if (flush) begin
            exp_q.delete();
            exp_pc_q.delete();
            m_next = {redirect_pc[31:2], 2'b00};
            if (completing) m_req = NONE;
            else if (m_req == LIVE) m_req = STALE;
        end else begin
            if (size_before != 0 && inst_ready) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (m_req == NONE) begin
                if (size_before < DEPTH) begin
                    m_req      = LIVE;
                    m_req_addr = m_next;
                end
            end else if (completing) begin
                if (m_req == LIVE) begin
                    exp_q.push_back(bus_rdata);
                    exp_pc_q.push_back(m_req_addr);
                    m_next = m_req_addr + 32'd4;
                    if (exp_q.size() < DEPTH) m_req_addr = m_next;
                    else m_req = NONE;
                end else begin
                    m_req = NONE;
                end
            end
        end
    endtask

    task automatic step(input logic f, input logic [31:0] rpc, input logic rdy, input logic bsy);
        @(negedge CLK);
        flush       = f;
        redirect_pc = rpc;
        inst_ready  = rdy;
        bus_busy    = bsy;
        bus_rdata   = $urandom;
        #1 check_outputs();
        @(posedge CLK);
        model_edge();
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        #1;
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        check(tag, inst_pc, pc);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST        = 1'b1;
        flush      = 1'b0;
        inst_ready = 1'b0;
        bus_busy   = 1'b0;
        #1;
        model_reset();
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_bus_ren", {31'd0, bus_ren}, 32'd0);
        check("rst_bus_addr", bus_addr, RESET_PC);
        @(posedge CLK);
        #2 RST = 1'b0;
    endtask

    initial begin
        RST         = 1'b1;
        flush       = 1'b0;
        redirect_pc = 32'd0;
        inst_ready  = 1'b0;
        bus_busy    = 1'b0;
        bus_rdata   = 32'd0;
        model_reset();
        #1;
        check("init_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("init_bus_ren", {31'd0, bus_ren}, 32'd0);
        check("init_bus_addr", bus_addr, RESET_PC);
        @(posedge CLK);
        #2 RST = 1'b0;

        // Streaming with a ready consumer.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        expect_head("stream0", 32'h80000000);
        step(0, 0, 1, 0);
        expect_head("stream1", 32'h80000004);
        step(0, 0, 1, 0);
        expect_head("stream2", 32'h80000008);

        // Fill with a stalled consumer, then release one entry.
        apply_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        #1 check("full_ren_low", {31'd0, bus_ren}, 32'd0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        #1 check("refill_addr", bus_addr, 32'h80000010);
        step(0, 0, 0, 0);

        // Flush while a read is stalled on bus_busy.
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(1, 32'h00001002, 0, 1);
        #1 check("discard_valid", {31'd0, inst_valid}, 32'd0);
        step(0, 0, 1, 1);
        #1 check("discard_addr", bus_addr, 32'h80000014);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        #1 check("redirect_addr", bus_addr, 32'h00001000);

        // Flush coinciding with a completion and a pop.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(1, 32'h00002000, 1, 0);
        #1 check("flush_cmp_valid", {31'd0, inst_valid}, 32'd0);
        step(0, 0, 1, 0);
        #1 check("flush_cmp_addr", bus_addr, 32'h00002000);

        // Address wrap at the top of the space.
        step(1, 32'hFFFFFFF8, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        expect_head("wrap0", 32'hFFFFFFF8);
        step(0, 0, 1, 0);
        expect_head("wrap1", 32'hFFFFFFFC);
        step(0, 0, 1, 0);
        expect_head("wrap2", 32'h00000000);

        // Reset with entries buffered and a read outstanding.
        apply_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        apply_reset();
        step(0, 0, 0, 0);
        #1 check("post_rst_addr", bus_addr, 32'h80000000);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        f;
            logic [31:0] rpc;
            f   = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            if (i == 300) apply_reset();
            step(f, rpc, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stage3_prefetch_buffer.md
STAGE3_PREFETCH_BUFFER -- requirements
Module: stage3_prefetch_buffer

Interface
REQ-001 Parameter RESET_PC, default 32'h80000000, SHALL be the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, power of two >= 2, SHALL be the number of buffered instruction entries.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 flush  in  1  SHALL request a redirect of the prefetch stream.
REQ-006 redirect_pc  in  32  SHALL be the new stream address, sampled when flush=1.
REQ-007 inst_ready  in  1  SHALL indicate the fetch stage accepts the head entry.
REQ-008 inst_valid  out  1  SHALL indicate the head entry is valid.
REQ-009 inst  out  32  SHALL be the head entry instruction word.
REQ-010 inst_pc  out  32  SHALL be the head entry address.
REQ-011 bus_addr  out  32  SHALL be the instruction bus read address.
REQ-012 bus_ren  out  1  SHALL be the instruction bus read request.
REQ-013 bus_byte_en  out  4  SHALL be the read byte enables, constant 4'hF.
REQ-014 bus_busy  in  1  SHALL be the bus busy; a read completes in any cycle with bus_ren=1 and bus_busy=0.
REQ-015 bus_rdata  in  32  SHALL be the read data, valid in the completion cycle.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH {pc, inst} entries with head/tail pointers mod DEPTH and count 0..DEPTH.
REQ-017 inst_valid SHALL equal (count != 0); inst/inst_pc SHALL be the head entry combinationally.
REQ-018 A pop SHALL occur when inst_valid=1 and inst_ready=1 and flush=0.
REQ-019 fetch_pc register SHALL hold the next address to request; it SHALL advance by 4 on each accepted completion, wrapping 32'hFFFFFFFC -> 0.
REQ-020 FSM states SHALL be IDLE, REQ, DISCARD; at most one bus read outstanding.
REQ-021 IDLE: bus_ren=0; -> REQ when flush=0 and count < DEPTH.
REQ-022 REQ: bus_ren=1, bus_addr=fetch_pc held stable until completion; on completion push {fetch_pc, bus_rdata}; stay REQ if post-update count < DEPTH, else -> IDLE.
REQ-023 DISCARD: bus_ren=1, bus_addr = address of the abandoned request held stable; on completion data SHALL be dropped and FSM -> IDLE.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push SHALL never occur when count=DEPTH (space reserved at issue).
REQ-025 flush SHALL, in the same edge: clear count and pointers, load fetch_pc <= {redirect_pc[31:2], 2'b00}, override any pop.
REQ-026 flush in REQ without completion that cycle SHALL -> DISCARD, latching the old address; flush in REQ with completion SHALL drop the data and -> IDLE.
REQ-027 flush in DISCARD SHALL update fetch_pc and remain DISCARD (or -> IDLE if completing that cycle); flush in IDLE SHALL stay IDLE.
REQ-028 No bus request SHALL be issued with a stale address after a flush; the first post-flush request SHALL use the redirect address.
REQ-029 With bus_busy=0 continuously and inst_ready=0, the first instruction SHALL become valid 2 cycles after RST deasserts and the FIFO SHALL fill in DEPTH+1 cycles.

Reset
REQ-030 While RST=1: count=0, pointers=0, FSM=IDLE, fetch_pc=RESET_PC, bus_ren=0, inst_valid=0, bus_addr=RESET_PC.
REQ-031 RST asserted mid-read SHALL abandon the read immediately; the bus owner is reset in the same domain.

Verification
REQ-032 Reset release, bus_busy=0, inst_ready=1 -> inst_pc sequence 0x80000000, 0x80000004, 0x80000008 on consecutive cycles.
REQ-033 inst_ready=0, bus_busy=0 -> 4 entries fill, bus_ren drops to 0, count stays 4; inst_ready=1 for 1 cycle -> one pop, one refill at 0x80000010.
REQ-034 Flush to 0x00001002 while REQ stalled on bus_busy=1 -> DISCARD holds old addr until busy=0, data dropped, next request addr 0x00001000, inst_valid=0 meanwhile.
REQ-035 Flush coincident with completion and pop -> count=0, completed data not visible, next request at redirect address.
REQ-036 redirect_pc 0xFFFFFFF8, bus_busy=0 -> inst_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-037 RST asserted with 3 entries and read outstanding -> inst_valid=0 and bus_ren=0 immediately; after release first request at 0x80000000.
